// File: rtl/branch_resolve_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | branch_resolve_ctrl_pkg : shared types for the branch resolve controller
// | Rev 1.0
// +-----------------------------------------------------------------------------
package branch_resolve_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } brc_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } brc_entry_t;

  localparam logic [31:0] C_PC_INC = 32'd4;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_ctrl_inflight_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | brc_inflight_fifo : in-order circular queue of in-flight branch predictions
// | Rev 1.0
// +-----------------------------------------------------------------------------
module brc_inflight_fifo
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  brc_entry_t             push_data,
  input  logic                   pop,
  input  logic                   clear,
  output brc_entry_t             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  brc_entry_t       mem_q [DEPTH];
  brc_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so a full queue may still accept a push
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | branch_resolve_ctrl : tracks predicted branches, trains predictor, flushes on mispredict
// | Optional BRC_STATS_EN adds saturating resolve/mispredict counters.  Rev 1.0
// +-----------------------------------------------------------------------------
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pred_valid,
  input  logic        pred_taken,
  input  logic [31:0] pred_pc,
  input  logic [31:0] pred_target,
  output logic        pred_ready,
  input  logic        res_valid,
  input  logic        res_taken,
  output logic        upd_valid,
  output logic        upd_taken,
  output logic [31:0] upd_pc,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        res_err
`ifdef BRC_STATS_EN
  ,
  output logic [15:0] stat_resolved,
  output logic [15:0] stat_mispred
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  brc_state_e       state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic             upd_valid_q, upd_valid_d;
  logic             upd_taken_q, upd_taken_d;
  logic [31:0]      upd_pc_q, upd_pc_d;
  logic             flush_q, flush_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             res_err_q, res_err_d;

  brc_entry_t       fifo_head;
  brc_entry_t       fifo_wdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             pop;
  logic             push;
  logic             mispred;

  // A resolve on a full queue frees its slot this cycle, so the push is accepted alongside it
  assign pred_ready = (state_q == ST_RUN) &&
                      ((fifo_count < CNT_W'(DEPTH)) || (fifo_full && res_valid));

  assign pop        = res_valid && !fifo_empty;
  assign mispred    = pop && (fifo_head.taken != res_taken);
  assign push       = pred_valid && pred_ready && !mispred;
  assign fifo_wdata = '{pc: pred_pc, target: pred_target, taken: pred_taken};

  brc_inflight_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (fifo_wdata),
    .pop       (pop),
    .clear     (mispred),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    upd_valid_d   = pop;
    upd_taken_d   = pop ? res_taken : upd_taken_q;
    upd_pc_d      = pop ? fifo_head.pc : upd_pc_q;
    flush_d       = mispred;
    redirect_pc_d = redirect_pc_q;
    res_err_d     = res_valid && fifo_empty;

    if (mispred) begin
      redirect_pc_d = res_taken ? fifo_head.target : (fifo_head.pc + C_PC_INC);
    end

    case (state_q)
      ST_RUN: begin
        if (mispred) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = 4'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      flush_cnt_q   <= 4'd0;
      upd_valid_q   <= 1'b0;
      upd_taken_q   <= 1'b0;
      upd_pc_q      <= 32'd0;
      flush_q       <= 1'b0;
      redirect_pc_q <= 32'd0;
      res_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      upd_valid_q   <= upd_valid_d;
      upd_taken_q   <= upd_taken_d;
      upd_pc_q      <= upd_pc_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      res_err_q     <= res_err_d;
    end
  end

  assign upd_valid   = upd_valid_q;
  assign upd_taken   = upd_taken_q;
  assign upd_pc      = upd_pc_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_pc_q;
  assign res_err     = res_err_q;

`ifdef BRC_STATS_EN
  logic [15:0] stat_resolved_q, stat_resolved_d;
  logic [15:0] stat_mispred_q, stat_mispred_d;

  always_comb begin
    stat_resolved_d = stat_resolved_q;
    stat_mispred_d  = stat_mispred_q;
    if (pop && (stat_resolved_q != 16'hFFFF)) begin
      stat_resolved_d = stat_resolved_q + 16'd1;
    end
    if (mispred && (stat_mispred_q != 16'hFFFF)) begin
      stat_mispred_d = stat_mispred_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_resolved_q <= 16'd0;
      stat_mispred_q  <= 16'd0;
    end else begin
      stat_resolved_q <= stat_resolved_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule
`default_nettype wire
